// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC sequencer.
// Q5.10 data, state encoding and iteration limits.
package cordic_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LIN,
    S_LIN,
    S_LOAD_HYP,
    S_HYP,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic MODE_LIN = 1'b0;
  localparam logic MODE_HYP = 1'b1;

  localparam logic [3:0] LIN_LAST_I   = 4'd10;
  localparam logic [3:0] HYP_FIRST_I  = 4'd1;
  localparam logic [3:0] HYP_LAST_I   = 4'd10;
  localparam logic [3:0] HYP_REPEAT_I = 4'd4;

  // 1/Kh in Q5.10, preloaded so the hyperbolic pass is unity gain
  localparam logic [15:0] KH_INV = 16'h04D4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or
// after ptr wins; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] j;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Job sequencer/arbiter for the shared iterative CORDIC core.
// CORDIC_HYP_REPEAT_EN: repeat hyperbolic iteration i=4.
module cordic_seq_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*(WIDTH+1)-1:0] req_x,
  input  logic [NREQ*(WIDTH+1)-1:0] req_z,
  input  logic [NREQ-1:0]           req_af,
  output logic [NREQ-1:0]           gnt,
  output logic                      core_load,
  output logic                      core_step,
  output logic                      core_mode,
  output logic [3:0]                core_i,
  output logic [WIDTH:0]            core_x0,
  output logic [WIDTH:0]            core_y0,
  output logic [WIDTH:0]            core_z0,
  input  logic [WIDTH:0]            core_xout,
  input  logic [WIDTH:0]            core_yout,
  input  logic [WIDTH:0]            core_zout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [IDW-1:0]            res_id,
  output logic                      res_af,
  output logic [WIDTH:0]            res_x,
  output logic [WIDTH:0]            res_y,
  output logic                      busy
);

  localparam int DW = WIDTH + 1;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [IDW-1:0] ptr, job_id, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [DW-1:0]  job_x, job_z;
  logic           job_af;
  logic           take;
`ifdef CORDIC_HYP_REPEAT_EN
  logic           rep, rep_nxt;
`endif

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign take      = (state == S_IDLE) && (|req) && !reset;
  assign gnt       = take ? arb_gnt : '0;
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef CORDIC_HYP_REPEAT_EN
    rep_nxt   = rep;
`endif
    core_load = 1'b0;
    core_step = 1'b0;
    core_mode = MODE_LIN;
    core_i    = '0;
    core_x0   = '0;
    core_y0   = '0;
    core_z0   = '0;
    unique case (state)
      S_IDLE: begin
        if (|req) state_nxt = S_LOAD_LIN;
      end
      S_LOAD_LIN: begin
        core_load = 1'b1;
        core_x0   = job_x;
        core_z0   = job_z;
        cnt_nxt   = '0;
        state_nxt = S_LIN;
      end
      S_LIN: begin
        core_step = 1'b1;
        core_i    = cnt;
        if (cnt == LIN_LAST_I)
          state_nxt = job_af ? S_LOAD_HYP : S_CAP;
        else
          cnt_nxt = cnt + 4'd1;
      end
      S_LOAD_HYP: begin
        core_load = 1'b1;
        core_mode = MODE_HYP;
        core_x0   = DW'(KH_INV);
        core_z0   = core_yout;
        cnt_nxt   = HYP_FIRST_I;
`ifdef CORDIC_HYP_REPEAT_EN
        rep_nxt   = 1'b0;
`endif
        state_nxt = S_HYP;
      end
      S_HYP: begin
        core_step = 1'b1;
        core_mode = MODE_HYP;
        core_i    = cnt;
`ifdef CORDIC_HYP_REPEAT_EN
        if (cnt == HYP_REPEAT_I && !rep)
          rep_nxt = 1'b1;
        else if (cnt == HYP_LAST_I)
          state_nxt = S_CAP;
        else
          cnt_nxt = cnt + 4'd1;
`else
        if (cnt == HYP_LAST_I)
          state_nxt = S_CAP;
        else
          cnt_nxt = cnt + 4'd1;
`endif
      end
      S_CAP: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ptr    <= '0;
      job_id <= '0;
      job_x  <= '0;
      job_z  <= '0;
      job_af <= 1'b0;
      res_id <= '0;
      res_af <= 1'b0;
      res_x  <= '0;
      res_y  <= '0;
`ifdef CORDIC_HYP_REPEAT_EN
      rep    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef CORDIC_HYP_REPEAT_EN
      rep   <= rep_nxt;
`endif
      if (take) begin
        job_id <= arb_idx;
        job_x  <= req_x[arb_idx*DW +: DW];
        job_z  <= req_z[arb_idx*DW +: DW];
        job_af <= req_af[arb_idx];
      end
      if (state == S_CAP) begin
        res_x  <= core_xout;
        res_y  <= core_yout;
        res_id <= job_id;
        res_af <= job_af;
      end
      // rotate priority past the requester just served
      if (res_valid && res_ready)
        ptr <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl with a behavioural CORDIC core model
// and a result scoreboard.
module tb_cordic_seq_ctrl;

`ifdef CORDIC_HYP_REPEAT_EN
  localparam int LAT_ACT = 26;
  localparam bit REP     = 1'b1;
`else
  localparam int LAT_ACT = 25;
  localparam bit REP     = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_x = '0;
  logic [63:0] req_z = '0;
  logic [3:0]  req_af = '0;
  logic [3:0]  gnt;
  logic        core_load, core_step, core_mode;
  logic [3:0]  core_i;
  logic [15:0] core_x0, core_y0, core_z0;
  logic [15:0] core_xout, core_yout, core_zout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [1:0]  res_id;
  logic        res_af;
  logic [15:0] res_x, res_y;
  logic        busy;

  cordic_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .req(req), .req_x(req_x), .req_z(req_z), .req_af(req_af),
    .gnt(gnt),
    .core_load(core_load), .core_step(core_step),
    .core_mode(core_mode), .core_i(core_i),
    .core_x0(core_x0), .core_y0(core_y0), .core_z0(core_z0),
    .core_xout(core_xout), .core_yout(core_yout),
    .core_zout(core_zout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_af(res_af),
    .res_x(res_x), .res_y(res_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // core model: rotation mode, Q5.10, d = sign(z)
  logic signed [15:0] mx = '0, my = '0, mz = '0;
  assign core_xout = mx;
  assign core_yout = my;
  assign core_zout = mz;

  function automatic logic signed [15:0] atanh_t(input logic [3:0] i);
    case (i)
      4'd1:    return 16'sd562;
      4'd2:    return 16'sd262;
      4'd3:    return 16'sd129;
      4'd4:    return 16'sd64;
      4'd5:    return 16'sd32;
      4'd6:    return 16'sd16;
      4'd7:    return 16'sd8;
      4'd8:    return 16'sd4;
      4'd9:    return 16'sd2;
      default: return 16'sd1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mx <= '0; my <= '0; mz <= '0;
    end else if (core_load) begin
      mx <= core_x0; my <= core_y0; mz <= core_z0;
    end else if (core_step) begin
      if (!core_mode) begin
        my <= mz[15] ? my - (mx >>> core_i) : my + (mx >>> core_i);
        mz <= mz[15] ? mz + (16'sd1024 >>> core_i)
                     : mz - (16'sd1024 >>> core_i);
      end else begin
        mx <= mz[15] ? mx - (my >>> core_i) : mx + (my >>> core_i);
        my <= mz[15] ? my - (mx >>> core_i) : my + (mx >>> core_i);
        mz <= mz[15] ? mz + atanh_t(core_i) : mz - atanh_t(core_i);
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int id; logic [15:0] x, z; logic af;
    int ex, ey, tx, ty, lat;
  } vec_t;

  typedef struct {
    int id; logic af; int ex, ey, tx, ty, lat, g;
  } sb_t;

  sb_t         sb[$];
  vec_t        tbl[5];
  logic        rec = 1'b0;
  logic [4:0]  steps[$];
  logic [15:0] hyp_z0 = '0;

  always @(negedge clk) begin
    if (core_load || core_step) begin
      n_chk++;
      if (core_load && core_step) begin
        n_fail++;
        $display("FAIL load_step_overlap: load=%b step=%b, required not both",
                 core_load, core_step);
      end
      if (rec && core_step) steps.push_back({core_mode, core_i});
      if (rec && core_load && core_mode) hyp_z0 = core_z0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp,
                         input int tol);
    n_chk++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, {gnt, core_load, core_step, core_mode, core_i,
                       res_valid, res_id, res_af, busy}, 64'd0);
    chk({nm, "_core"}, {core_x0, core_y0, core_z0}, 64'd0);
    chk({nm, "_res"}, {res_x, res_y}, 64'd0);
  endtask

  task automatic start_job(input logic [3:0] mask, input int idx,
                           input logic [15:0] x, input logic [15:0] z,
                           input logic af, input int ex, input int ey,
                           input int tx, input int ty, input int lat);
    int t;
    sb_t e;
    logic [3:0] one;
    one = 4'b0001;
    req_x[idx*16 +: 16] = x;
    req_z[idx*16 +: 16] = z;
    req_af[idx] = af;
    req = mask | (one << idx);
    #1;
    t = 0;
    while (gnt == 4'd0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (gnt == 4'd0) begin
      n_chk++;
      n_fail++;
      $display("FAIL gnt_timeout: no gnt in 50 cycles, required id %0d", idx);
      req = '0;
      return;
    end
    chk("gnt", gnt, one << idx);
    e.id = idx; e.af = af; e.ex = ex; e.ey = ey;
    e.tx = tx; e.ty = ty; e.lat = lat; e.g = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req[idx] = 1'b0;
  endtask

  task automatic finish_job(input int stall);
    int t;
    sb_t e;
    logic [34:0] snap;
    t = 0;
    while (!res_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!res_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL res_timeout: no res_valid in 60 cycles, required 1");
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: result with no job, required a job");
      return;
    end
    e = sb.pop_front();
    chk("latency", 64'(cyc - e.g), 64'(e.lat));
    chk("res_id", res_id, 64'(e.id));
    chk("res_af", res_af, e.af);
    chk_tol("res_x", int'($signed(res_x)), e.ex, e.tx);
    chk_tol("res_y", int'($signed(res_y)), e.ey, e.ty);
    snap = {res_id, res_af, res_x, res_y};
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_res", {res_valid, res_id, res_af, res_x, res_y},
          {1'b1, snap});
      chk("hold_gnt", gnt, 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] exps[$];
    int nv;

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // {id, x, z, af, res_x, res_y, tol_x, tol_y, latency}
    tbl[0] = '{0, 16'h0400, 16'h0200, 1'b0, 1024, 512, 0, 2, 14};
    tbl[1] = '{1, 16'h0800, 16'h0180, 1'b0, 2048, 768, 0, 2, 14};
    tbl[2] = '{3, 16'hFC00, 16'h0100, 1'b0, -1024, -256, 0, 2, 14};
    tbl[3] = '{2, 16'h0200, 16'hFF00, 1'b0, 512, -128, 0, 2, 14};
    tbl[4] = '{0, 16'h0400, 16'h0200, 1'b1, 1155, 534, 4, 4, LAT_ACT};
    for (int i = 0; i < 5; i++) begin
      start_job(4'd0, tbl[i].id, tbl[i].x, tbl[i].z, tbl[i].af,
                tbl[i].ex, tbl[i].ey, tbl[i].tx, tbl[i].ty, tbl[i].lat);
      finish_job(0);
    end

    // step sequence of a full activation job
    steps.delete();
    rec = 1'b1;
    start_job(4'd0, 3, 16'h0400, 16'h0200, 1'b1, 1155, 534, 4, 4, LAT_ACT);
    finish_job(0);
    rec = 1'b0;
    for (int i = 0; i <= 10; i++) exps.push_back({1'b0, 4'(i)});
    for (int i = 1; i <= 10; i++) begin
      exps.push_back({1'b1, 4'(i)});
      if (REP && i == 4) exps.push_back({1'b1, 4'(i)});
    end
    chk("step_count", 64'(steps.size()), 64'(exps.size()));
    nv = (steps.size() < exps.size()) ? steps.size() : exps.size();
    for (int k = 0; k < nv; k++)
      chk($sformatf("step%0d_mode_i", k), steps[k], exps[k]);
    chk_tol("hyp_z0", int'($signed(hyp_z0)), 512, 2);

    // round robin from a fresh pointer
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      start_job(4'b1111, k, 16'h0400, 16'((k + 1) * 128), 1'b0,
                1024, (k + 1) * 128, 0, 2, 14);
      finish_job(0);
    end
    start_job(4'b0110, 1, 16'h0400, 16'h0080, 1'b0, 1024, 128, 0, 2, 14);
    finish_job(0);

    // backpressure with requester 0 waiting; pointer now at 2
    req_x[15:0] = 16'h0400;
    req_z[15:0] = 16'h0300;
    req_af[0]   = 1'b0;
    start_job(4'b0001, 2, 16'h0400, 16'h0100, 1'b0, 1024, 256, 0, 2, 14);
    finish_job(10);
    chk("bp_valid_drop", res_valid, 64'd0);
    chk("bp_next_gnt", gnt, 64'h1);
    start_job(4'b0001, 0, 16'h0400, 16'h0300, 1'b0, 1024, 768, 0, 2, 14);
    finish_job(0);

    // reset in the middle of a job
    start_job(4'd0, 1, 16'h0400, 16'h0100, 1'b0, 1024, 256, 0, 2, 14);
    nv = 0;
    while (sb.size() > 0 && cyc - sb[sb.size()-1].g < 8 && nv < 20) begin
      @(negedge clk);
      nv++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("mid_reset");
    reset = 1'b0;
    chk("mid_reset_sb", 64'(sb.size()), 64'd1);
    sb.delete();
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || busy) nv++;
    end
    chk("no_result_after_reset", 64'(nv), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
